fp_add_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational FP32 adder among N requesters, such as neuron accumulators and bias stages. It grants one requester at a time and registers that requester's operands onto the adder inputs. It captures the adder output one cycle later and returns it on a tagged response channel with a valid/ready handshake. It also bypasses the adder when either operand is ±0, because the shared adder cannot normalise a zero sum.

---
 rtl/fp_add_arbiter.sv | 129 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP32 adder among N requesters.
// Operands are registered onto the adder, and the sum comes back on a tagged valid/ready channel.
module fp_add_arbiter #(
    parameter int N  = 4,
    parameter int TW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [32*N-1:0] req_a,
    input  logic [32*N-1:0] req_b,
    output logic [31:0]     add_a,
    output logic [31:0]     add_b,
    input  logic [31:0]     add_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_data,
    output logic [TW-1:0]   rsp_tag,
    output logic            busy
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] tag_q, tag_d;
    logic [31:0]   add_a_q, add_a_d;
    logic [31:0]   add_b_q, add_b_d;
    logic [31:0]   rsp_data_q, rsp_data_d;

    logic [31:0]   op_a [N];
    logic [31:0]   op_b [N];
    logic [PW-1:0] grant;
    logic          grant_vld;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign op_a[gi] = req_a[32*gi +: 32];
            assign op_b[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // First valid requester at or after ptr, wrapping past N-1.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tag_d      = tag_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    add_a_d          = op_a[grant];
                    add_b_d          = op_b[grant];
                    tag_d            = TW'(grant);
                    ptr_d            = (int'(grant) == N - 1) ? '0 : grant + PW'(1);
                    state_d          = CALC;
                end
            end
            CALC: begin
                // The shared adder cannot normalise a zero sum, so a signless-zero operand bypasses it.
                if (add_a_q[30:0] == 31'd0) begin
                    rsp_data_d = add_b_q;
                end else if (add_b_q[30:0] == 31'd0) begin
                    rsp_data_d = add_a_q;
                end else begin
                    rsp_data_d = add_result;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tag_q      <= '0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tag_q      <= tag_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = tag_q;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: real-arithmetic adder stand-in plus a
// transaction-level round-robin and zero-bypass reference model.
module tb_fp_add_arbiter;
    localparam int N  = 4;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [31:0]     add_a;
    logic [31:0]     add_b;
    logic [31:0]     add_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [31:0]     rsp_data;
    logic [TW-1:0]   rsp_tag;
    logic            busy;

    logic [31:0] opa [N];
    logic [31:0] opb [N];
    logic        force_dead = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          model_ptr = 0;

    fp_add_arbiter #(.N(N), .TW(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[32*gi +: 32] = opa[gi];
            assign req_b[32*gi +: 32] = opb[gi];
        end
    endgenerate

    function automatic real f2r(input logic [31:0] x);
        real v;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        e = int'(x[30:23]) - 127;
        v = 1.0 + real'(x[22:0]) / 8388608.0;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural stand-in for the shared adder.
    always_comb add_result = force_dead ? 32'hDEADBEEF : r2f(f2r(add_a) + f2r(add_b));

    function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic int model_grant(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 4) == 0) return {r[31], 31'd0};
        return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
    endfunction

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_ptr = 0;
    endtask

    // Issues one request with rsp_ready held high; returns the observed grant and response.
    task automatic drive_txn(input logic [N-1:0] mask, output logic [N-1:0] rr,
                             output logic rv, output logic [31:0] data, output logic [TW-1:0] tag);
        @(posedge clk); #1;
        req_valid = mask;
        rsp_ready = 1'b1;
        @(negedge clk);
        rr = req_ready;
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(negedge clk);
        rv   = rsp_valid;
        data = rsp_data;
        tag  = rsp_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin opa[i] = 32'h3F800000; opb[i] = 32'h40000000; end
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (add_a !== 32'd0 || add_b !== 32'd0) begin
            errors++; $display("FAIL reset_add_ops got %h/%h want 0/0", add_a, add_b);
        end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        checks++; if (rsp_tag !== '0) begin errors++; $display("FAIL reset_rsp_tag got %0d want 0", rsp_tag); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== oh(model_grant(4'b1010, 0))) begin
            errors++; $display("FAIL reset_comb_grant got %b want %b", req_ready, oh(model_grant(4'b1010, 0)));
        end
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_single();
        opa[2] = 32'h3F800000;
        opb[2] = 32'h40000000;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        model_ptr = 3;
        @(negedge clk);
        checks++; if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
            errors++; $display("FAIL single_add_ops got %h/%h want 3f800000/40000000", add_a, add_b);
        end
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_calc got busy=%b rsp_valid=%b want 1/0", busy, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 32'h40400000) begin errors++; $display("FAIL single_rsp_data got %h want 40400000", rsp_data); end
        checks++; if (rsp_tag !== 3'd2) begin errors++; $display("FAIL single_rsp_tag got %0d want 2", rsp_tag); end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle got busy=%b rsp_valid=%b want 0/0", busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int g;
        int last;
        int n;
        do_reset();
        last = -1;
        n    = 0;
        @(posedge clk); #1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                g = model_grant('1, model_ptr);
                checks++; if (req_ready !== oh(g)) begin
                    errors++; $display("FAIL rr_grant%0d got %b want %b", n, req_ready, oh(g));
                end
                if (last >= 0) begin
                    checks++; if (cyc - last != 3) begin
                        errors++; $display("FAIL rr_interval%0d got %0d want 3", n, cyc - last);
                    end
                end
                model_ptr = (g + 1) % N;
                last = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        req_valid = '0;
        checks++; if (n != 6) begin errors++; $display("FAIL rr_count got %0d want 6", n); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap_skip();
        logic [N-1:0]  rr;
        logic          rv;
        logic [31:0]   d;
        logic [TW-1:0] t;
        do_reset();
        for (int i = 0; i < N; i++) begin opa[i] = 32'h40000000; opb[i] = 32'h40400000; end
        drive_txn(4'b0100, rr, rv, d, t);
        checks++; if (rr !== 4'b0100) begin errors++; $display("FAIL wrap_setup got %b want 0100", rr); end
        model_ptr = 3;
        drive_txn(4'b1010, rr, rv, d, t);
        checks++; if (rr !== oh(model_grant(4'b1010, model_ptr))) begin
            errors++; $display("FAIL wrap_first got %b want %b", rr, oh(model_grant(4'b1010, model_ptr)));
        end
        checks++; if (t !== 3'd3) begin errors++; $display("FAIL wrap_first_tag got %0d want 3", t); end
        model_ptr = 0;
        drive_txn(4'b1010, rr, rv, d, t);
        checks++; if (rr !== 4'b0010) begin errors++; $display("FAIL wrap_second got %b want 0010", rr); end
        checks++; if (t !== 3'd1 || d !== 32'h40A00000) begin
            errors++; $display("FAIL wrap_second_rsp got tag=%0d data=%h want 1/40a00000", t, d);
        end
        model_ptr = 2;
        drive_txn('1, rr, rv, d, t);
        checks++; if (rr !== 4'b0100) begin errors++; $display("FAIL wrap_ptr got %b want 0100", rr); end
        model_ptr = 3;
    endtask

    task automatic test_zero_bypass();
        logic [31:0]   ta [4];
        logic [31:0]   tbv[4];
        logic [31:0]   te [4];
        logic [N-1:0]  rr;
        logic          rv;
        logic [31:0]   d;
        logic [TW-1:0] t;
        ta[0] = 32'h80000000; tbv[0] = 32'h40A00000; te[0] = 32'h40A00000;
        ta[1] = 32'h41200000; tbv[1] = 32'h00000000; te[1] = 32'h41200000;
        ta[2] = 32'h00000000; tbv[2] = 32'h80000000; te[2] = 32'h80000000;
        ta[3] = 32'h3F800000; tbv[3] = 32'h40000000; te[3] = 32'hDEADBEEF;
        force_dead = 1'b1;
        for (int c = 0; c < 4; c++) begin
            opa[0] = ta[c];
            opb[0] = tbv[c];
            drive_txn(4'b0001, rr, rv, d, t);
            model_ptr = 1;
            checks++; if (rv !== 1'b1 || d !== te[c] || t !== 3'd0) begin
                errors++; $display("FAIL zero_case%0d got v=%b data=%h tag=%0d want 1/%h/0", c, rv, d, t, te[c]);
            end
        end
        force_dead = 1'b0;
    endtask

    task automatic test_stall();
        int          g;
        logic [31:0] ed;
        for (int i = 0; i < N; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
        @(posedge clk); #1;
        req_valid = '1;
        rsp_ready = 1'b0;
        @(negedge clk);
        g  = model_grant('1, model_ptr);
        ed = exp_result(opa[g], opb[g]);
        checks++; if (req_ready !== oh(g)) begin errors++; $display("FAIL stall_grant got %b want %b", req_ready, oh(g)); end
        @(posedge clk); #1;
        model_ptr = (g + 1) % N;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_tag !== TW'(g) || req_ready !== '0) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b data=%h tag=%0d rdy=%b want 1/%h/%0d/0",
                         c, rsp_valid, rsp_data, rsp_tag, req_ready, ed, g);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        g = model_grant('1, model_ptr);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== oh(g)) begin
            errors++; $display("FAIL stall_release got busy=%b v=%b rdy=%b want 0/0/%b", busy, rsp_valid, req_ready, oh(g));
        end
        @(posedge clk); #1;
        model_ptr = (g + 1) % N;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        opa[2] = 32'h40E00000;
        opb[2] = 32'h3F000000;
        @(posedge clk); #1;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || add_a !== 32'h40E00000) begin
            errors++; $display("FAIL midrst_calc got busy=%b add_a=%h want 1/40e00000", busy, add_a);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_state got busy=%b v=%b want 0/0", busy, rsp_valid);
        end
        checks++; if (add_a !== 32'd0 || add_b !== 32'd0 || rsp_data !== 32'd0) begin
            errors++; $display("FAIL midrst_regs got %h/%h/%h want 0/0/0", add_a, add_b, rsp_data);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale%0d got %b want 0", c, rsp_valid); end
        end
        @(posedge clk); #1;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== oh(model_grant('1, model_ptr))) begin
            errors++; $display("FAIL midrst_ptr got %b want %b", req_ready, oh(model_grant('1, model_ptr)));
        end
        @(posedge clk); #1;
        model_ptr = (model_grant('1, model_ptr) + 1) % N;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        int           g;
        int           stall;
        logic [31:0]  ea;
        logic [31:0]  eb;
        logic [31:0]  ed;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
            mask      = N'($urandom_range(1, (1 << N) - 1));
            req_valid = mask;
            rsp_ready = 1'b0;
            @(negedge clk);
            g  = model_grant(mask, model_ptr);
            ea = opa[g];
            eb = opb[g];
            ed = exp_result(ea, eb);
            checks++; if (req_ready !== oh(g)) begin errors++; $display("FAIL rnd%0d_grant got %b want %b", t, req_ready, oh(g)); end
            @(posedge clk); #1;
            model_ptr = (g + 1) % N;
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin opa[i] = rand_op(); opb[i] = rand_op(); end
            @(negedge clk);
            checks++; if (req_ready !== '0 || add_a !== ea || add_b !== eb) begin
                errors++; $display("FAIL rnd%0d_calc got rdy=%b ops=%h/%h want 0/%h/%h", t, req_ready, add_a, add_b, ea, eb);
            end
            @(posedge clk);
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_tag !== TW'(g)) begin
                errors++; $display("FAIL rnd%0d_rsp got v=%b data=%h tag=%0d want 1/%h/%0d", t, rsp_valid, rsp_data, rsp_tag, ed, g);
            end
            stall = $urandom_range(0, 3);
            repeat (stall) begin
                @(posedge clk);
                @(negedge clk);
                checks++; if (rsp_valid !== 1'b1 || rsp_data !== ed || req_ready !== '0) begin
                    errors++; $display("FAIL rnd%0d_stall got v=%b data=%h rdy=%b want 1/%h/0", t, rsp_valid, rsp_data, req_ready, ed);
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            req_valid = '0;
            rsp_ready = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_idle got busy=%b v=%b want 0/0", t, busy, rsp_valid);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_zero_bypass();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
